expr_recognizer: RTL

//   Streaming recognizer for arithmetic expressions, one ASCII char per accepted cycle.

---
 rtl/expr_pkg.sv | 30 +++
 rtl/expr_char_class.sv | 34 +++
 rtl/expr_recognizer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/expr_pkg.sv
// Shared types and ASCII constants for the streaming expression recognizer.
package expr_pkg;

    typedef enum logic [1:0] {
        S_EXP = 2'd0,
        S_NUM = 2'd1,
        S_END = 2'd2,
        S_ERR = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CC_DIGIT,
        CC_OP,
        CC_LP,
        CC_RP,
        CC_SP,
        CC_BAD
    } cclass_t;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_LP    = 8'h28;
    localparam logic [7:0] CH_RP    = 8'h29;
    localparam logic [7:0] CH_SP    = 8'h20;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII character classifier for expr_recognizer.
// Parenthesis classes are produced only when EXPR_PAREN_EN is defined.
module expr_char_class
    import expr_pkg::*;
#(
    parameter logic [3:0] OP_MASK    = 4'b0011,
    parameter bit         SKIP_SPACE = 1'b0
) (
    input  logic [7:0] ch,
    output cclass_t    cls
);

    always_comb begin
        cls = CC_BAD;
        if (ch >= CH_0 && ch <= CH_9) begin
            cls = CC_DIGIT;
        end else begin
            // Disabled operators and disabled spaces fall through as CC_BAD.
            case (ch)
                CH_PLUS:  if (OP_MASK[0]) cls = CC_OP;
                CH_STAR:  if (OP_MASK[1]) cls = CC_OP;
                CH_MINUS: if (OP_MASK[2]) cls = CC_OP;
                CH_SLASH: if (OP_MASK[3]) cls = CC_OP;
                CH_SP:    if (SKIP_SPACE) cls = CC_SP;
`ifdef EXPR_PAREN_EN
                CH_LP:    cls = CC_LP;
                CH_RP:    cls = CC_RP;
`endif
                default:  cls = CC_BAD;
            endcase
        end
    end

endmodule

// File: rtl/expr_recognizer.sv
// Streaming recognizer for "operand (op operand)*" with sticky error and operand count.
// Define EXPR_PAREN_EN to accept parenthesised sub-expressions up to MAX_DEPTH deep.
module expr_recognizer
    import expr_pkg::*;
#(
    parameter int unsigned MAX_DIGITS = 3,
    parameter logic [3:0]  OP_MASK    = 4'b0011,
    parameter bit          SKIP_SPACE = 1'b0,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned MAX_DEPTH  = 7
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in,
    output logic             out,
    output logic             err,
    output logic [CNT_W-1:0] term_cnt,
    output logic [2:0]       depth
);

    localparam int unsigned    DW     = $clog2(MAX_DIGITS + 1);
    localparam logic [DW-1:0]  DMAX   = DW'(MAX_DIGITS);
    localparam logic [2:0]     DEPMAX = 3'(MAX_DEPTH);
`ifdef EXPR_PAREN_EN
    localparam bit PAREN = 1'b1;
`else
    localparam bit PAREN = 1'b0;
`endif

    cclass_t          cls;
    state_t           state, state_nx;
    logic [DW-1:0]    dcnt, dcnt_nx;
    logic [CNT_W-1:0] term, term_nx;
    logic [2:0]       dep, dep_nx;
    logic             out_q, err_q;

    expr_char_class #(
        .OP_MASK    (OP_MASK),
        .SKIP_SPACE (SKIP_SPACE)
    ) u_class (
        .ch  (in),
        .cls (cls)
    );

    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        term_nx  = term;
        dep_nx   = dep;
        if (in_valid) begin
            unique case (state)
                S_EXP: begin
                    case (cls)
                        CC_DIGIT: begin
                            state_nx = S_NUM;
                            dcnt_nx  = DW'(1);
                            if (term != '1) term_nx = term + 1'b1;
                        end
                        CC_SP: ;
                        CC_LP: begin
                            if (dep == DEPMAX) state_nx = S_ERR;
                            else               dep_nx   = dep + 3'd1;
                        end
                        default: state_nx = S_ERR;
                    endcase
                end
                S_NUM: begin
                    case (cls)
                        CC_DIGIT: begin
                            if (dcnt == DMAX) state_nx = S_ERR;
                            else              dcnt_nx  = dcnt + 1'b1;
                        end
                        CC_OP: state_nx = S_EXP;
                        CC_SP: state_nx = S_END;
                        CC_RP: begin
                            if (dep == 3'd0) begin
                                state_nx = S_ERR;
                            end else begin
                                dep_nx   = dep - 3'd1;
                                state_nx = S_END;
                            end
                        end
                        default: state_nx = S_ERR;
                    endcase
                end
                S_END: begin
                    case (cls)
                        CC_OP: state_nx = S_EXP;
                        CC_SP: ;
                        CC_RP: begin
                            if (dep == 3'd0) state_nx = S_ERR;
                            else             dep_nx   = dep - 3'd1;
                        end
                        default: state_nx = S_ERR;
                    endcase
                end
                S_ERR: ;
            endcase
        end
    end

    // Flags are computed from the next state so they change on the same edge as the char.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_EXP;
            dcnt  <= '0;
            term  <= '0;
            dep   <= '0;
            out_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            dcnt  <= dcnt_nx;
            term  <= term_nx;
            dep   <= PAREN ? dep_nx : '0;
            out_q <= (state_nx == S_NUM || state_nx == S_END) && (dep_nx == 3'd0);
            err_q <= (state_nx == S_ERR);
        end
    end

    assign out      = out_q;
    assign err      = err_q;
    assign term_cnt = term;
    assign depth    = dep;

endmodule
